// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch -> decode instruction queue.
//   PC_W, INSTR_W, HIST_W : default datapath widths
//   NOP_INSTR/NOP_PC/NOP_NPC : values shown to decode on a bubble; they match
//                              what the decode pipeline register loads when it
//                              inserts a bubble itself
//   fq_entry_t             : one queued fetch packet
//   nop_entry()            : the bubble packet
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int HIST_W  = 8;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [PC_W-1:0]    NOP_PC    = '0;
    localparam logic [PC_W-1:0]    NOP_NPC   = '0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    npc;
        logic [INSTR_W-1:0] instr;
        logic               predict;
        logic               train_valid;
        logic [HIST_W-1:0]  history;
    } fq_entry_t;

    function automatic fq_entry_t nop_entry();
        fq_entry_t e;
        e.pc          = NOP_PC;
        e.npc         = NOP_NPC;
        e.instr       = NOP_INSTR;
        e.predict     = 1'b0;
        e.train_valid = 1'b0;
        e.history     = '0;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// fetch_queue_mem
// DEPTH x fq_entry_t register array, one synchronous write port and one
// asynchronous read port. Contents are not reset: validity is tracked by the
// pointer/count control in fetch_queue.
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : entry to write
//   raddr_i  : read index
//   rdata_o  : entry at raddr_i (combinational)
// -----------------------------------------------------------------------------
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  fq_entry_t                wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output fq_entry_t                rdata_o
);

    fq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction queue between fetch and the decode pipeline register. Buffers
// fetched instructions with PC, predicted nPC and predictor training info so
// fetch can keep running while decode stalls. The head entry is presented to
// decode; an empty queue (or a flush cycle) presents a NOP bubble.
//
// Ports
//   clk_i, rst            : clock (rising edge), async active-high reset
//   F_valid_i/F_ready_o   : fetch push handshake
//   F_PC_i, F_nPC_i, F_instr_i, F_train_predict_i, F_train_vaild_i,
//   F_train_history_i     : fetch packet
//   D_stall_i             : decode holds its current instruction
//   flush_i               : redirect, discard all entries
//   D_valid_o, D_commit_o : head is a real instruction
//   D_PC_o, D_nPC_o, D_instr_o, D_train_*_o : head packet (NOP when invalid)
//   count_o               : occupancy 0..DEPTH
//
// Build option
//   FETCH_QUEUE_BYPASS_EN : when the queue is empty, an offered fetch packet is
//                           shown to decode in the same cycle; if decode is not
//                           stalled it is consumed without being written.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    // Widths must agree with fetch_pkg, which sizes the stored entry.
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int HIST_W  = fetch_pkg::HIST_W
) (
    input  logic                       clk_i,
    input  logic                       rst,

    input  logic                       F_valid_i,
    input  logic [PC_W-1:0]            F_PC_i,
    input  logic [PC_W-1:0]            F_nPC_i,
    input  logic [INSTR_W-1:0]         F_instr_i,
    input  logic                       F_train_predict_i,
    input  logic                       F_train_vaild_i,
    input  logic [HIST_W-1:0]          F_train_history_i,
    output logic                       F_ready_o,

    input  logic                       D_stall_i,
    input  logic                       flush_i,

    output logic                       D_valid_o,
    output logic [PC_W-1:0]            D_PC_o,
    output logic [PC_W-1:0]            D_nPC_o,
    output logic [INSTR_W-1:0]         D_instr_o,
    output logic                       D_train_predict_o,
    output logic                       D_train_vaild_o,
    output logic [HIST_W-1:0]          D_train_history_o,
    output logic                       D_commit_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic      empty;
    logic      byp;
    logic      push;
    logic      pop_mem;
    logic      head_valid;
    fq_entry_t f_entry;
    fq_entry_t rd_entry;
    fq_entry_t head;

    assign f_entry.pc          = F_PC_i;
    assign f_entry.npc         = F_nPC_i;
    assign f_entry.instr       = F_instr_i;
    assign f_entry.predict     = F_train_predict_i;
    assign f_entry.train_valid = F_train_vaild_i;
    assign f_entry.history     = F_train_history_i;

    assign empty     = (count_q == '0);
    // Full/empty come from count only; pointers alias when full.
    assign F_ready_o = (count_q != FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = empty & F_valid_i & ~flush_i;
`else
    assign byp = 1'b0;
`endif

    // A bypassed packet that decode takes right away never enters storage.
    assign push    = F_valid_i & F_ready_o & ~flush_i & ~(byp & ~D_stall_i);
    assign pop_mem = ~empty & ~D_stall_i & ~flush_i;

    assign head_valid = (~empty | byp) & ~flush_i;

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (f_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_mem) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop_mem) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop_mem) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head = nop_entry();
        if (head_valid) begin
            head = empty ? f_entry : rd_entry;
        end
    end

    assign D_valid_o         = head_valid;
    assign D_commit_o        = head_valid;
    assign D_PC_o            = head.pc;
    assign D_nPC_o           = head.npc;
    assign D_instr_o         = head.instr;
    assign D_train_predict_o = head.predict;
    assign D_train_vaild_o   = head.train_valid;
    assign D_train_history_o = head.history;
    assign count_o           = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] NOP_I  = 32'h0000_0013;
    localparam logic [31:0] NOP_PC = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst   = 1'b1;
    logic        F_valid_i = 1'b0;
    logic [31:0] F_PC_i = '0, F_nPC_i = '0, F_instr_i = '0;
    logic        F_train_predict_i = 1'b0, F_train_vaild_i = 1'b0;
    logic [7:0]  F_train_history_i = '0;
    logic        F_ready_o;
    logic        D_stall_i = 1'b0, flush_i = 1'b0;
    logic        D_valid_o, D_commit_o, D_train_predict_o, D_train_vaild_o;
    logic [31:0] D_PC_o, D_nPC_o, D_instr_o;
    logic [7:0]  D_train_history_o;
    logic [2:0]  count_o;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst(rst),
        .F_valid_i(F_valid_i), .F_PC_i(F_PC_i), .F_nPC_i(F_nPC_i),
        .F_instr_i(F_instr_i), .F_train_predict_i(F_train_predict_i),
        .F_train_vaild_i(F_train_vaild_i), .F_train_history_i(F_train_history_i),
        .F_ready_o(F_ready_o), .D_stall_i(D_stall_i), .flush_i(flush_i),
        .D_valid_o(D_valid_o), .D_PC_o(D_PC_o), .D_nPC_o(D_nPC_o),
        .D_instr_o(D_instr_o), .D_train_predict_o(D_train_predict_o),
        .D_train_vaild_o(D_train_vaild_o), .D_train_history_o(D_train_history_o),
        .D_commit_o(D_commit_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc, npc, instr;
        logic        pr, tv;
        logic [7:0]  hist;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.npc   = pc + 32'd4;
        e.instr = 32'hA000_0000 | pc;
        e.pr    = pc[2];
        e.tv    = pc[3];
        e.hist  = pc[9:2];
        return e;
    endfunction

    // Offer a packet; 'acc' says whether the hand analysis expects it taken.
    task automatic drive(logic [31:0] pc, bit acc);
        exp_t e;
        e = mk(pc);
        F_valid_i = 1'b1;
        F_PC_i = e.pc; F_nPC_i = e.npc; F_instr_i = e.instr;
        F_train_predict_i = e.pr; F_train_vaild_i = e.tv; F_train_history_i = e.hist;
        if (acc) expq.push_back(e);
    endtask

    task automatic idle();
        F_valid_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every instruction decode consumes is compared with the scoreboard.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst && D_valid_o && !D_stall_i && !flush_i) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_extra: got PC %0h required no instruction", D_PC_o);
            end else begin
                e = expq.pop_front();
                check("pop_pc",     D_PC_o,            e.pc);
                check("pop_npc",    D_nPC_o,           e.npc);
                check("pop_instr",  D_instr_o,         e.instr);
                check("pop_pred",   D_train_predict_o, e.pr);
                check("pop_tv",     D_train_vaild_o,   e.tv);
                check("pop_hist",   D_train_history_o, e.hist);
                check("pop_commit", D_commit_o,        1);
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk_i);
        check("rst_valid",  D_valid_o,  0);
        check("rst_commit", D_commit_o, 0);
        check("rst_instr",  D_instr_o,  NOP_I);
        check("rst_pc",     D_PC_o,     NOP_PC);
        check("rst_train",  {D_train_predict_o, D_train_vaild_o, D_train_history_o}, 0);
        check("rst_ready",  F_ready_o,  1);
        check("rst_count",  count_o,    0);
        step();
        rst = 1'b0;

        // Back-to-back pushes with no stall
        drive(32'h100, 1); @(negedge clk_i); check("t1_cnt0", count_o, 0); step();
        drive(32'h104, 1); @(negedge clk_i); check("t1_cnt1", count_o, BYP ? 0 : 1); step();
        drive(32'h108, 1); @(negedge clk_i); check("t1_cnt2", count_o, BYP ? 0 : 1); step();
        idle();            @(negedge clk_i); check("t1_cnt3", count_o, BYP ? 0 : 1); step();
        @(negedge clk_i);
        check("t1_idle_valid",  D_valid_o,  0);
        check("t1_idle_commit", D_commit_o, 0);
        check("t1_idle_count",  count_o,    0);
        step();

        // Stall and fill past capacity
        D_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'h300 + 32'(4 * i), i < 4);
            @(negedge clk_i);
            check("t2_ready", F_ready_o, (i < 4) ? 1 : 0);
            check("t2_count", count_o, i);
            if (i >= 1) check("t2_hold_pc", D_PC_o, 32'h300);
            step();
        end

        // Release the stall at full, fetch keeps offering
        D_stall_i = 1'b0;
        drive(32'h314, 0); @(negedge clk_i);
        check("t3_ready_full", F_ready_o, 0); check("t3_cnt_full", count_o, 4); step();
        drive(32'h314, 1); @(negedge clk_i);
        check("t3_ready_back", F_ready_o, 1); check("t3_cnt_b", count_o, 3); step();
        drive(32'h318, 1); @(negedge clk_i); check("t3_cnt_c", count_o, 3); step();
        drive(32'h31C, 1); @(negedge clk_i); check("t3_cnt_d", count_o, 3); step();

        // Flush at count=3 with a simultaneous push
        flush_i = 1'b1;
        drive(32'h320, 0);
        expq.delete();
        #1;
        check("t4_flush_valid",  D_valid_o,  0);
        check("t4_flush_commit", D_commit_o, 0);
        check("t4_flush_instr",  D_instr_o,  NOP_I);
        check("t4_flush_cnt",    count_o,    3);
        step();
        flush_i = 1'b0;
        idle();
        @(negedge clk_i);
        check("t4_post_count", count_o,   0);
        check("t4_post_valid", D_valid_o, 0);
        check("t4_post_ready", F_ready_o, 1);
        step();

        // Asynchronous reset with two entries held
        D_stall_i = 1'b1;
        drive(32'h400, 1); step();
        drive(32'h404, 1); step();
        idle();
        #1;
        check("t5_pre_count", count_o,   2);
        check("t5_pre_valid", D_valid_o, 1);
        rst = 1'b1;
        expq.delete();
        #1;
        check("t5_rst_valid",  D_valid_o,  0);
        check("t5_rst_commit", D_commit_o, 0);
        check("t5_rst_count",  count_o,    0);
        check("t5_rst_ready",  F_ready_o,  1);
        check("t5_rst_instr",  D_instr_o,  NOP_I);
        step();
        rst = 1'b0;
        D_stall_i = 1'b0;
        @(negedge clk_i);
        check("t5_after_valid", D_valid_o, 0);
        step();

        // Latency from empty
        drive(32'h200, 1);
        #1;
        check("t6_same_valid", D_valid_o, BYP ? 1 : 0);
        check("t6_same_pc",    D_PC_o,    BYP ? 32'h200 : NOP_PC);
        check("t6_same_cnt",   count_o,   0);
        step();
        idle();
        #1;
        check("t6_next_valid", D_valid_o, BYP ? 0 : 1);
        check("t6_next_cnt",   count_o,   BYP ? 0 : 1);
        step();
        @(negedge clk_i);
        check("t6_final_cnt", count_o, 0);
        step();

        check("drain", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction queue between the fetch stage and the decode pipeline register.
- Decouples fetch from decode stalls by buffering fetched instructions together with their PC, predicted next-PC and branch-predictor training info.
- Presents the head entry to decode, or a NOP bubble when the queue is empty.
- Redirects from execute (mispredict/jump) flush the whole queue.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PC_W, 32, PC / nPC width.
- INSTR_W, 32, instruction width.
- HIST_W, 8, branch-history width carried for predictor training.

Ports:
- clk_i  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- F_valid_i  in  1  fetch offers an instruction this cycle.
- F_PC_i  in  PC_W  PC of the offered instruction.
- F_nPC_i  in  PC_W  predicted next PC.
- F_instr_i  in  INSTR_W  instruction word.
- F_train_predict_i  in  1  predictor taken/not-taken.
- F_train_vaild_i  in  1  prediction info valid (branch).
- F_train_history_i  in  HIST_W  history snapshot.
- F_ready_o  out  1  queue can accept a push this cycle.
- D_stall_i  in  1  decode holds its current instruction.
- flush_i  in  1  redirect; discard all entries.
- D_valid_o  out  1  head entry is valid.
- D_PC_o  out  PC_W  head PC.
- D_nPC_o  out  PC_W  head nPC.
- D_instr_o  out  INSTR_W  head instruction.
- D_train_predict_o  out  1  head predictor bit.
- D_train_vaild_o  out  1  head prediction-valid bit.
- D_train_history_o  out  HIST_W  head history.
- D_commit_o  out  1  head is a real, committable instruction (equals D_valid_o).
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits that wrap naturally, plus a count register. count range is 0..DEPTH.
- Reset (async, rst=1):
  - rd_ptr=0, wr_ptr=0, count=0; storage contents are don't-care.
  - Outputs while in reset: D_valid_o=0, D_commit_o=0, D_PC_o=NOP_PC, D_nPC_o=NOP_NPC, D_instr_o=NOP_INSTR (32'h00000013), train outputs 0, F_ready_o=1, count_o=0.
- F_ready_o = (count != DEPTH). It is registered-state based only: there is no push-while-full even when a pop happens in the same cycle.
- push = F_valid_i & F_ready_o & ~flush_i. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = D_valid_o & ~D_stall_i & ~flush_i. On pop, rd_ptr increments.
- count_next = count + push - pop. A simultaneous push and pop leaves count unchanged, including at count=1 and count=DEPTH-1.
- Head outputs are driven combinationally from the entry at rd_ptr when count != 0.
  - When count == 0: D_valid_o=0 and all D_* outputs carry NOP values (bubble).
- Latency: an instruction pushed at edge N is visible on the D_* outputs after edge N (one cycle), provided everything older has been popped.
- Stall: while D_stall_i=1, the head and all D_* outputs are held stable; pushes continue until the queue is full.
- Flush: when flush_i=1 in a cycle, at the next edge rd_ptr=wr_ptr=0, count=0, and any same-cycle push is dropped.
  - In the flush cycle itself, D_valid_o and D_commit_o are forced to 0 and the D_* outputs show NOP values.
  - Flush overrides stall.
- Reset mid-operation: all entries are lost immediately and no partial write survives.
- Pointer wrap at DEPTH-1 -> 0 is seamless; full and empty are distinguished by count, never by pointer comparison.

Optional Feature:
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0, F_valid_i=1 and flush_i=0, the fetch inputs drive the D_* outputs in the same cycle, with D_valid_o=1.
  - If additionally D_stall_i=0, the instruction is consumed directly and is not written (count stays 0).
  - If D_stall_i=1, it is pushed normally.
  - Zero-cycle latency when empty.
- Not defined: no combinational fetch-to-decode path; minimum latency is one cycle, as described in Behaviour.

Decomposition:
- Shared package fetch_pkg holds:
  - width constants PC_W, INSTR_W, HIST_W;
  - NOP_INSTR, NOP_PC, NOP_NPC (matching the NOP values the decode pipeline register uses on bubble);
  - typedef fq_entry_t {pc, npc, instr, predict, train_valid, history}.
- One natural sub-module: fetch_queue_mem, a DEPTH x fq_entry_t register array with one write port and one async read port. The pointer/count control stays in fetch_queue.

Test Plan:
- Reset, then push PCs 0x100, 0x104, 0x108 on consecutive cycles with D_stall_i=0 -> D_PC_o shows 0x100, 0x104, 0x108 on the cycles after each push; count_o peaks at 1; D_commit_o=1 only on those cycles.
- Hold D_stall_i=1 and push 5 instructions at DEPTH=4 -> F_ready_o falls after the 4th push, the 5th is not accepted, count_o=4, and D_PC_o is held at the first PC throughout.
- At count=4, release the stall and keep F_valid_i=1 -> one pop per cycle; F_ready_o returns the cycle after the first pop; FIFO order is preserved across the rd_ptr/wr_ptr wrap (PCs in increasing order).
- At count=3, assert flush_i together with F_valid_i -> D_valid_o=0 and D_instr_o=32'h00000013 in that cycle; count_o=0 next cycle; the flush-cycle push is absent.
- Assert rst asynchronously mid-cycle with count=2 -> D_valid_o drops immediately without waiting for a clock edge, count_o=0, F_ready_o=1.
- With FETCH_QUEUE_BYPASS_EN, empty queue, push PC 0x200 with D_stall_i=0 -> D_PC_o=0x200 in the same cycle and count_o stays 0. Without the macro -> 0x200 appears one cycle later.
